// File: rtl/memoria_pkg.sv
// Shared types and helpers for the memory (cartas) game logic.
package memoria_pkg;

  typedef enum logic [2:0] {PICK1, PICK2, CMP, SHOW, DONE} flip_state_t;

  localparam int GRID_ROWS = 4;
  localparam int GRID_COLS = 4;
  localparam int NCARDS    = GRID_ROWS * GRID_COLS;
  localparam int IDX_W     = $clog2(NCARDS);

  // Linear card index for a grid position, row-major.
  function automatic int card_index(input int row, input int col, input int ncols = GRID_COLS);
    return row * ncols + col;
  endfunction

endpackage

// File: rtl/card_flip_controller_hold_timer.sv
// Countdown that keeps a mismatched pair visible; loads HOLD_CYCLES-1 and
// counts down to zero, raising zero_o while it rests at zero.
module hold_timer #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [TMR_W-1:0] count_q, count_d;

  // Load has priority over decrement; the count never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = TMR_W'(HOLD_CYCLES - 1);
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - TMR_W'(1);
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/card_flip_controller.sv
// Game logic of the 4x4 memory game: cursor, card flipping, pair comparison,
// mismatch hold and score keeping.
module card_flip_controller
  import memoria_pkg::*;
#(
  parameter int N_ROWS      = GRID_ROWS,
  parameter int N_COLS      = GRID_COLS,
  parameter int ID_W        = 3,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                btn_up,
  input  logic                                btn_down,
  input  logic                                btn_left,
  input  logic                                btn_right,
  input  logic                                btn_sel,
  input  logic [N_ROWS*N_COLS*ID_W-1:0]       card_id,
  output logic [N_ROWS*N_COLS-1:0]            face_up,
  output logic [N_ROWS*N_COLS-1:0]            matched,
  output logic [$clog2(N_ROWS)-1:0]           cursor_row,
  output logic [$clog2(N_COLS)-1:0]           cursor_col,
  output logic [7:0]                          attempts,
  output logic [$clog2(N_ROWS*N_COLS/2):0]    pairs_found,
  output logic                                game_over
);

  localparam int CARDS  = N_ROWS * N_COLS;
  localparam int CIDX_W = $clog2(CARDS);
  localparam int ROW_W  = $clog2(N_ROWS);
  localparam int COL_W  = $clog2(N_COLS);
  localparam int PF_W   = $clog2(CARDS / 2) + 1;

  flip_state_t        state_q, state_d;
  logic [ROW_W-1:0]   cursorRow_q, cursorRow_d;
  logic [COL_W-1:0]   cursorCol_q, cursorCol_d;
  logic [CARDS-1:0]   faceUp_q, faceUp_d;
  logic [CARDS-1:0]   matched_q, matched_d;
  logic [CIDX_W-1:0]  first_q, first_d;
  logic [CIDX_W-1:0]  second_q, second_d;
  logic [7:0]         attempts_q, attempts_d;
  logic [PF_W-1:0]    pairs_q, pairs_d;

  logic [CIDX_W-1:0]  curIdx;
  logic               selOk, idsEqual, lastPair, timerZero;
  logic               moveEn, flipEn, storeFirst, storeSecond, cmpEn;
  logic               loadTimer, decTimer, hidePair, over;

  assign curIdx   = CIDX_W'(card_index(int'(cursorRow_q), int'(cursorCol_q), N_COLS));
  assign selOk    = btn_sel && !faceUp_q[curIdx];
  assign idsEqual = (card_id[int'(first_q)*ID_W +: ID_W] == card_id[int'(second_q)*ID_W +: ID_W]);
  assign lastPair = (pairs_q == PF_W'(CARDS / 2 - 1));

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .load_i(loadTimer),
    .dec_i (decTimer),
    .zero_o(timerZero)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PICK1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: two picks, one compare cycle, optional hold, then back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PICK1: if (selOk) state_d = PICK2;
      PICK2: if (selOk) state_d = CMP;
      CMP: begin
        if (idsEqual) begin
          state_d = lastPair ? DONE : PICK1;
        end else begin
          state_d = SHOW;
        end
      end
      SHOW:    if (timerZero) state_d = PICK1;
      DONE:    state_d = DONE;
      default: state_d = PICK1;
    endcase
  end

  // Per-state control strobes for the datapath and timer.
  always_comb begin
    moveEn      = 1'b0;
    flipEn      = 1'b0;
    storeFirst  = 1'b0;
    storeSecond = 1'b0;
    cmpEn       = 1'b0;
    loadTimer   = 1'b0;
    decTimer    = 1'b0;
    hidePair    = 1'b0;
    over        = 1'b0;
    case (state_q)
      PICK1: begin
        moveEn     = 1'b1;
        flipEn     = selOk;
        storeFirst = selOk;
      end
      PICK2: begin
        moveEn      = 1'b1;
        flipEn      = selOk;
        storeSecond = selOk;
      end
      CMP: begin
        moveEn    = 1'b1;
        cmpEn     = 1'b1;
        loadTimer = !idsEqual;
      end
      SHOW: begin
        moveEn   = 1'b1;
        decTimer = !timerZero;
        hidePair = timerZero;
      end
      DONE:    over = 1'b1;
      default: over = 1'b0;
    endcase
  end

  // Datapath next values; selection always uses the cursor before this cycle's move.
  always_comb begin
    faceUp_d    = faceUp_q;
    matched_d   = matched_q;
    first_d     = first_q;
    second_d    = second_q;
    attempts_d  = attempts_q;
    pairs_d     = pairs_q;
    cursorRow_d = cursorRow_q;
    cursorCol_d = cursorCol_q;

    if (flipEn)      faceUp_d[curIdx] = 1'b1;
    if (storeFirst)  first_d  = curIdx;
    if (storeSecond) second_d = curIdx;
    if (hidePair) begin
      faceUp_d[first_q]  = 1'b0;
      faceUp_d[second_q] = 1'b0;
    end
    if (cmpEn) begin
      if (attempts_q != 8'hFF) attempts_d = attempts_q + 8'd1;
      if (idsEqual) begin
        matched_d[first_q]  = 1'b1;
        matched_d[second_q] = 1'b1;
        pairs_d             = pairs_q + PF_W'(1);
      end
    end

    if (moveEn) begin
      if (btn_up) begin
        cursorRow_d = (cursorRow_q == '0) ? ROW_W'(N_ROWS - 1) : cursorRow_q - ROW_W'(1);
      end else if (btn_down) begin
        cursorRow_d = (cursorRow_q == ROW_W'(N_ROWS - 1)) ? '0 : cursorRow_q + ROW_W'(1);
      end else if (btn_left) begin
        cursorCol_d = (cursorCol_q == '0) ? COL_W'(N_COLS - 1) : cursorCol_q - COL_W'(1);
      end else if (btn_right) begin
        cursorCol_d = (cursorCol_q == COL_W'(N_COLS - 1)) ? '0 : cursorCol_q + COL_W'(1);
      end
    end
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      faceUp_q    <= '0;
      matched_q   <= '0;
      first_q     <= '0;
      second_q    <= '0;
      attempts_q  <= '0;
      pairs_q     <= '0;
      cursorRow_q <= '0;
      cursorCol_q <= '0;
    end else begin
      faceUp_q    <= faceUp_d;
      matched_q   <= matched_d;
      first_q     <= first_d;
      second_q    <= second_d;
      attempts_q  <= attempts_d;
      pairs_q     <= pairs_d;
      cursorRow_q <= cursorRow_d;
      cursorCol_q <= cursorCol_d;
    end
  end

  assign face_up     = faceUp_q;
  assign matched     = matched_q;
  assign cursor_row  = cursorRow_q;
  assign cursor_col  = cursorCol_q;
  assign attempts    = attempts_q;
  assign pairs_found = pairs_q;
  assign game_over   = over;

endmodule

// File: tb/tb_card_flip_controller.sv
// Self-checking bench for card_flip_controller: directed scenarios plus
// randomized play compared against a game-level reference model.
module tb_card_flip_controller;

  localparam int HOLD = 4;
  localparam int NC   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        btnUp, btnDown, btnLeft, btnRight, btnSel;
  logic [47:0] cardId;
  logic [15:0] faceUp, matchedV;
  logic [1:0]  curRow, curCol;
  logic [7:0]  attempts;
  logic [3:0]  pairsFound;
  logic        gameOver;

  int checks   = 0;
  int failures = 0;

  // Reference model state, kept in game terms.
  int ids[NC];
  bit mUp[NC];
  bit mMat[NC];
  int mRow, mCol, mAtt, mPairs, mHold, holdA, holdB;
  bit mCmp, mOver;
  int picks[$];

  card_flip_controller #(
    .N_ROWS(4), .N_COLS(4), .ID_W(3), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_up(btnUp), .btn_down(btnDown), .btn_left(btnLeft), .btn_right(btnRight),
    .btn_sel(btnSel), .card_id(cardId),
    .face_up(faceUp), .matched(matchedV),
    .cursor_row(curRow), .cursor_col(curCol),
    .attempts(attempts), .pairs_found(pairsFound), .game_over(gameOver)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  function automatic logic [15:0] packUp();
    logic [15:0] v = '0;
    for (int i = 0; i < NC; i++) v[i] = mUp[i];
    return v;
  endfunction

  function automatic logic [15:0] packMat();
    logic [15:0] v = '0;
    for (int i = 0; i < NC; i++) v[i] = mMat[i];
    return v;
  endfunction

  task automatic loadIds();
    for (int i = 0; i < NC; i++) cardId[i*3 +: 3] = 3'(ids[i]);
  endtask

  task automatic layoutPairs();
    for (int i = 0; i < NC; i++) ids[i] = i / 2;
    loadIds();
  endtask

  task automatic modelReset();
    for (int i = 0; i < NC; i++) begin
      mUp[i]  = 1'b0;
      mMat[i] = 1'b0;
    end
    mRow = 0; mCol = 0; mAtt = 0; mPairs = 0; mHold = 0;
    holdA = 0; holdB = 0; mCmp = 1'b0; mOver = 1'b0;
    picks.delete();
  endtask

  // One clock edge of game rules: compare, hold countdown, or a pick; then the cursor.
  task automatic modelStep(input bit u, input bit d, input bit l, input bit r, input bit s);
    int idx;
    bit wasOver;
    idx = mRow * 4 + mCol;
    wasOver = mOver;
    if (mCmp) begin
      if (mAtt < 255) mAtt++;
      if (ids[picks[0]] == ids[picks[1]]) begin
        mMat[picks[0]] = 1'b1;
        mMat[picks[1]] = 1'b1;
        mPairs++;
        if (mPairs == NC / 2) mOver = 1'b1;
      end else begin
        mHold = HOLD;
        holdA = picks[0];
        holdB = picks[1];
      end
      picks.delete();
      mCmp = 1'b0;
    end else if (mHold > 0) begin
      mHold--;
      if (mHold == 0) begin
        mUp[holdA] = 1'b0;
        mUp[holdB] = 1'b0;
      end
    end else if (!mOver && s && !mUp[idx]) begin
      mUp[idx] = 1'b1;
      picks.push_back(idx);
      if (picks.size() == 2) mCmp = 1'b1;
    end
    if (!wasOver) begin
      if (u)      mRow = (mRow + 3) % 4;
      else if (d) mRow = (mRow + 1) % 4;
      else if (l) mCol = (mCol + 3) % 4;
      else if (r) mCol = (mCol + 1) % 4;
    end
  endtask

  // Drive one cycle of buttons across a single rising edge, then sample 1 ns later.
  task automatic applyStimulus(input bit u, input bit d, input bit l, input bit r, input bit s);
    btnUp = u; btnDown = d; btnLeft = l; btnRight = r; btnSel = s;
    @(posedge clk);
    modelStep(u, d, l, r, s);
    #1;
    btnUp = 0; btnDown = 0; btnLeft = 0; btnRight = 0; btnSel = 0;
  endtask

  task automatic doReset();
    btnUp = 0; btnDown = 0; btnLeft = 0; btnRight = 0; btnSel = 0;
    rst = 1'b1;
    @(posedge clk);
    #2;
    modelReset();
    rst = 1'b0;
  endtask

  task automatic moveTo(input int card);
    for (int k = 0; k < 4 && mRow != card / 4; k++) applyStimulus(0, 1, 0, 0, 0);
    for (int k = 0; k < 4 && mCol != card % 4; k++) applyStimulus(0, 0, 0, 1, 0);
  endtask

  task automatic test_reset();
    layoutPairs();
    doReset();
    checks++;
    if ({faceUp, matchedV, curRow, curCol, attempts, pairsFound, gameOver} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_init: got up=%h mat=%h row=%0d col=%0d att=%0d pairs=%0d over=%b, required all 0",
               faceUp, matchedV, curRow, curCol, attempts, pairsFound, gameOver);
    end
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checks++;
    if (faceUp !== 16'h0005 || attempts !== 8'd1) begin
      failures++;
      $display("[TB] FAIL reset_setup_show: got up=%h att=%0d, required up=0005 att=1", faceUp, attempts);
    end
    rst = 1'b1;
    #2;
    checks++;
    if ({faceUp, matchedV, curRow, curCol, attempts, pairsFound, gameOver} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid_show: got up=%h mat=%h row=%0d col=%0d att=%0d pairs=%0d over=%b, required all 0",
               faceUp, matchedV, curRow, curCol, attempts, pairsFound, gameOver);
    end
    rst = 1'b0;
    modelReset();
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0);
    checks++;
    if (faceUp !== 16'h0001 || attempts !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_back_in_pick1: got up=%h att=%0d, required up=0001 att=0", faceUp, attempts);
    end
  endtask

  task automatic test_cursor_wrap();
    doReset();
    applyStimulus(1, 0, 0, 0, 0);
    checks++;
    if (curRow !== 2'd3 || curCol !== 2'd0) begin
      failures++;
      $display("[TB] FAIL cursor_up_wrap: got (%0d,%0d), required (3,0)", curRow, curCol);
    end
    applyStimulus(0, 0, 1, 0, 0);
    checks++;
    if (curRow !== 2'd3 || curCol !== 2'd3) begin
      failures++;
      $display("[TB] FAIL cursor_left_wrap: got (%0d,%0d), required (3,3)", curRow, curCol);
    end
    applyStimulus(1, 0, 0, 1, 0);
    checks++;
    if (curRow !== 2'd2 || curCol !== 2'd3) begin
      failures++;
      $display("[TB] FAIL cursor_up_over_right: got (%0d,%0d), required (2,3)", curRow, curCol);
    end
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checks++;
    if (curRow !== 2'd0 || curCol !== 2'd3) begin
      failures++;
      $display("[TB] FAIL cursor_down_wrap: got (%0d,%0d), required (0,3)", curRow, curCol);
    end
    applyStimulus(0, 0, 0, 1, 0);
    checks++;
    if (curRow !== 2'd0 || curCol !== 2'd0) begin
      failures++;
      $display("[TB] FAIL cursor_right_wrap: got (%0d,%0d), required (0,0)", curRow, curCol);
    end
  endtask

  task automatic test_match();
    layoutPairs();
    doReset();
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checks++;
    if (faceUp !== 16'h0003 || matchedV !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL match_flip: got up=%h mat=%h, required up=0003 mat=0000", faceUp, matchedV);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checks++;
    if (faceUp !== 16'h0003 || matchedV !== 16'h0003 || pairsFound !== 4'd1 || attempts !== 8'd1) begin
      failures++;
      $display("[TB] FAIL match_result: got up=%h mat=%h pairs=%0d att=%0d, required 0003 0003 1 1",
               faceUp, matchedV, pairsFound, attempts);
    end
  endtask

  task automatic test_mismatch();
    layoutPairs();
    doReset();
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checks++;
    if (faceUp !== 16'h0005 || attempts !== 8'd1 || matchedV !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL mismatch_enter_show: got up=%h att=%0d mat=%h, required 0005 1 0000",
               faceUp, attempts, matchedV);
    end
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checks++;
    if (faceUp !== 16'h0005) begin
      failures++;
      $display("[TB] FAIL mismatch_sel_in_show: got up=%h, required 0005", faceUp);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checks++;
    if (faceUp !== 16'h0005) begin
      failures++;
      $display("[TB] FAIL mismatch_hold_cycle4: got up=%h, required 0005", faceUp);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checks++;
    if (faceUp !== 16'h0000 || matchedV !== 16'h0000 || attempts !== 8'd1) begin
      failures++;
      $display("[TB] FAIL mismatch_hidden: got up=%h mat=%h att=%0d, required 0000 0000 1",
               faceUp, matchedV, attempts);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checks++;
    if (faceUp !== 16'h0008) begin
      failures++;
      $display("[TB] FAIL mismatch_pick_again: got up=%h, required 0008", faceUp);
    end
  endtask

  task automatic test_illegal_select();
    layoutPairs();
    doReset();
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checks++;
    if (faceUp !== 16'h0001 || attempts !== 8'd0) begin
      failures++;
      $display("[TB] FAIL illegal_same_card: got up=%h att=%0d, required 0001 0", faceUp, attempts);
    end
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checks++;
    if (matchedV !== 16'h0003 || attempts !== 8'd1) begin
      failures++;
      $display("[TB] FAIL illegal_then_pair: got mat=%h att=%0d, required 0003 1", matchedV, attempts);
    end
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checks++;
    if (faceUp !== 16'h0003 || attempts !== 8'd1) begin
      failures++;
      $display("[TB] FAIL illegal_matched_card: got up=%h att=%0d, required 0003 1", faceUp, attempts);
    end
  endtask

  task automatic test_full_game();
    layoutPairs();
    doReset();
    for (int p = 0; p < 8; p++) begin
      moveTo(2 * p);
      applyStimulus(0, 0, 0, 0, 1);
      moveTo(2 * p + 1);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
    end
    checks++;
    if (gameOver !== 1'b1 || faceUp !== 16'hFFFF || matchedV !== 16'hFFFF ||
        pairsFound !== 4'd8 || attempts !== 8'd8) begin
      failures++;
      $display("[TB] FAIL full_game_done: got over=%b up=%h mat=%h pairs=%0d att=%0d, required 1 FFFF FFFF 8 8",
               gameOver, faceUp, matchedV, pairsFound, attempts);
    end
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 1);
    checks++;
    if (gameOver !== 1'b1 || curRow !== 2'd3 || curCol !== 2'd3 ||
        attempts !== 8'd8 || pairsFound !== 4'd8 || faceUp !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL full_game_frozen: got over=%b (%0d,%0d) att=%0d pairs=%0d up=%h, required 1 (3,3) 8 8 FFFF",
               gameOver, curRow, curCol, attempts, pairsFound, faceUp);
    end
  endtask

  // Random play; round 0 uses shuffled legal pairs, round 1 arbitrary IDs.
  task automatic test_random(input int round, input int cycles);
    for (int i = 0; i < NC; i++) ids[i] = (round == 0) ? i / 2 : int'($urandom_range(0, 7));
    if (round == 0) begin
      for (int i = NC - 1; i > 0; i--) begin
        int j, t;
        j = int'($urandom_range(0, i));
        t = ids[i]; ids[i] = ids[j]; ids[j] = t;
      end
    end
    loadIds();
    doReset();
    for (int c = 0; c < cycles; c++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) == 1);
      checks++;
      if (faceUp !== packUp()) begin
        failures++;
        $display("[TB] FAIL rnd%0d_face_up cyc %0d: got %h required %h", round, c, faceUp, packUp());
      end
      checks++;
      if (matchedV !== packMat()) begin
        failures++;
        $display("[TB] FAIL rnd%0d_matched cyc %0d: got %h required %h", round, c, matchedV, packMat());
      end
      checks++;
      if (curRow !== 2'(mRow) || curCol !== 2'(mCol)) begin
        failures++;
        $display("[TB] FAIL rnd%0d_cursor cyc %0d: got (%0d,%0d) required (%0d,%0d)",
                 round, c, curRow, curCol, mRow, mCol);
      end
      checks++;
      if (attempts !== 8'(mAtt) || pairsFound !== 4'(mPairs)) begin
        failures++;
        $display("[TB] FAIL rnd%0d_counters cyc %0d: got att=%0d pairs=%0d required att=%0d pairs=%0d",
                 round, c, attempts, pairsFound, mAtt, mPairs);
      end
      checks++;
      if (gameOver !== mOver) begin
        failures++;
        $display("[TB] FAIL rnd%0d_game_over cyc %0d: got %b required %b", round, c, gameOver, mOver);
      end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    rst = 1'b1;
    btnUp = 0; btnDown = 0; btnLeft = 0; btnRight = 0; btnSel = 0;
    cardId = '0;
    modelReset();
    test_reset();
    test_cursor_wrap();
    test_match();
    test_mismatch();
    test_illegal_select();
    test_full_game();
    test_random(0, 1500);
    test_random(1, 1500);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
